alu_seq: RTL and testbench

- Parametrised next-generation ALU for the multi-cycle MIPS datapath.
- Adds the following to the single-cycle add/sub/or/slt set:
  - registered outputs;
  - a start/busy/done handshake;
  - AND/XOR/NOR/SLTU and signed SUB;
  - iterative MULT/MULTU/DIV/DIVU writing HI/LO registers.
- The control FSM stalls on busy while a multiply or divide iterates.

---
 rtl/alu_seq_if.sv | 28 ++
 rtl/alu_seq.sv | 229 ++++++++++++++++++++++
 tb/tb_alu_seq.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Handshake and data bundle between the datapath control and the sequential ALU.
// Requester drives start/op/operands; the ALU drives status, result and HI/LO.
// Shared by the RTL and the bench so the port list stays in one place.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, result, zero, overflow, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, zero, overflow, hi, lo
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential MIPS ALU: single-cycle logic/arith ops plus iterative MULT/DIV into HI/LO.
// Latency: 1 edge to done for single-cycle ops, WIDTH+2 edges for mul/div.
// Backpressure: busy high during CALC/FIX, start ignored then; DONE accepts a new start.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic      clk,
  input logic      reset,
  alu_seq_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [3:0] OP_ADDU  = 4'h0;
  localparam logic [3:0] OP_SUBU  = 4'h1;
  localparam logic [3:0] OP_OR    = 4'h2;
  localparam logic [3:0] OP_SLT   = 4'h3;
  localparam logic [3:0] OP_ADD   = 4'h4;
  localparam logic [3:0] OP_SUB   = 4'h5;
  localparam logic [3:0] OP_AND   = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_NOR   = 4'h8;
  localparam logic [3:0] OP_SLTU  = 4'h9;
  localparam logic [3:0] OP_MULT  = 4'hA;
  localparam logic [3:0] OP_MULTU = 4'hB;
  localparam logic [3:0] OP_DIV   = 4'hC;
  localparam logic [3:0] OP_DIVU  = 4'hD;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_INT  = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  // Operation context captured when a mul/div is accepted
  logic             mul_q;     // 1 = multiply, 0 = divide
  logic             neg_res;   // product/quotient must be negated
  logic             neg_rem;   // remainder must be negated (dividend was negative)
  logic             dz_q;      // divide by zero
  logic             dovf_q;    // MIN_INT / -1
  logic [WIDTH-1:0] a_q;       // raw dividend, returned in HI on divide by zero
  logic [WIDTH-1:0] mag_b;     // |b| (or b for unsigned)
  logic [WIDTH-1:0] acc;       // product high half / partial remainder
  logic [WIDTH-1:0] mq;        // multiplier-product low half / dividend-quotient

  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             ovf_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  assign bus.busy     = (state == CALC) || (state == FIX);
  assign bus.done     = (state == DONE);
  assign bus.result   = result_q;
  assign bus.zero     = zero_q;
  assign bus.overflow = ovf_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

  // Request decode
  logic             is_long;
  logic             is_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] mag_a_in;
  logic [WIDTH-1:0] mag_b_in;

  assign is_long   = (bus.op == OP_MULT) || (bus.op == OP_MULTU) ||
                     (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
  assign is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign a_neg     = is_signed & bus.a[WIDTH-1];
  assign b_neg     = is_signed & bus.b[WIDTH-1];
  assign mag_a_in  = a_neg ? -bus.a : bus.a;
  assign mag_b_in  = b_neg ? -bus.b : bus.b;

  // Sign-extended sum/difference so signed overflow is visible in the top two bits
  logic [WIDTH:0] sum_ext;
  logic [WIDTH:0] diff_ext;
  assign sum_ext  = {bus.a[WIDTH-1], bus.a} + {bus.b[WIDTH-1], bus.b};
  assign diff_ext = {bus.a[WIDTH-1], bus.a} - {bus.b[WIDTH-1], bus.b};

  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;

  // Single-cycle result; illegal and long opcodes fall through to zero
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (bus.op)
      OP_ADDU: alu_res = bus.a + bus.b;
      OP_SUBU: alu_res = bus.a - bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_ADD: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_ovf = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];
      end
      OP_SUB: begin
        alu_res = diff_ext[WIDTH-1:0];
        alu_ovf = diff_ext[WIDTH] ^ diff_ext[WIDTH-1];
      end
      OP_AND:  alu_res = bus.a & bus.b;
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_NOR:  alu_res = ~(bus.a | bus.b);
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      default: alu_res = '0;
    endcase
  end

  logic [WIDTH:0]   madd;
  logic [WIDTH:0]   dshift;
  logic [WIDTH:0]   dsub;
  logic             dge;
  logic [WIDTH-1:0] acc_n;
  logic [WIDTH-1:0] mq_n;

  // One iteration: shift-add multiply, or restoring shift-subtract divide
  always_comb begin
    madd   = {1'b0, acc} + (mq[0] ? {1'b0, mag_b} : '0);
    dshift = {acc, mq[WIDTH-1]};
    dsub   = dshift - {1'b0, mag_b};
    dge    = ~dsub[WIDTH];
    if (mul_q) begin
      acc_n = madd[WIDTH:1];
      mq_n  = {madd[0], mq[WIDTH-1:1]};
    end else begin
      acc_n = dge ? dsub[WIDTH-1:0] : dshift[WIDTH-1:0];
      mq_n  = {mq[WIDTH-2:0], dge};
    end
  end

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;
  logic               fix_ovf;

  // Sign correction and divide exception handling for the final write
  always_comb begin
    prod_fix = neg_res ? -{acc, mq} : {acc, mq};
    quo_fix  = neg_res ? -mq : mq;
    rem_fix  = neg_rem ? -acc : acc;
    fix_ovf  = 1'b0;
    if (mul_q) begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end else if (dz_q) begin
      fix_hi  = a_q;
      fix_lo  = '1;
      fix_ovf = 1'b1;
    end else begin
      fix_hi  = rem_fix;
      fix_lo  = quo_fix;
      fix_ovf = dovf_q;
    end
  end

  // Control FSM and all registered state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      mul_q    <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      dz_q     <= 1'b0;
      dovf_q   <= 1'b0;
      a_q      <= '0;
      mag_b    <= '0;
      acc      <= '0;
      mq       <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (bus.start) begin
            if (is_long) begin
              mul_q   <= (bus.op == OP_MULT) || (bus.op == OP_MULTU);
              neg_res <= a_neg ^ b_neg;
              neg_rem <= a_neg && (bus.op == OP_DIV);
              dz_q    <= (bus.b == '0);
              dovf_q  <= (bus.op == OP_DIV) && (bus.a == MIN_INT) && (bus.b == '1);
              a_q     <= bus.a;
              mag_b   <= mag_b_in;
              acc     <= '0;
              mq      <= mag_a_in;
              cnt     <= '0;
              state   <= CALC;
            end else begin
              result_q <= alu_res;
              zero_q   <= (alu_res == '0);
              ovf_q    <= alu_ovf;
              state    <= DONE;
            end
          end
        end
        CALC: begin
          acc <= acc_n;
          mq  <= mq_n;
          if (cnt == CNT_LAST) begin
            state <= FIX;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        FIX: begin
          hi_q     <= fix_hi;
          lo_q     <= fix_lo;
          result_q <= fix_lo;
          zero_q   <= (fix_lo == '0);
          ovf_q    <= fix_ovf;
          state    <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: single-cycle ops, mul/div HI/LO, exceptions, handshake, reset.
// Latency is counted in rising edges, starting with the edge that samples start (= 1).
// Expected values are hand-computed constants in the vector tables below.
module tb_alu_seq;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  alu_seq_if #(.WIDTH(32)) bus ();

  alu_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
  } sc_vec_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        ovf;
  } md_vec_t;

  sc_vec_t sc_tab[15];
  md_vec_t md_tab[11];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op; optionally poke an ADD start at edge count 'poke'; returns latency in edges
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int poke, output int lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.start = 1'b0;
    while (!bus.done && lat < 200) begin
      if (poke != 0 && lat == poke) begin
        bus.start = 1'b1;
        bus.op    = 4'h4;
        bus.a     = 32'd1;
        bus.b     = 32'd1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    if (!bus.done) check("timeout_done", 32'(bus.done), 32'd1);
  endtask

  initial begin
    int lat;
    int pulses;

    checks   = 0;
    failures = 0;

    sc_tab[0]  = '{4'h4, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1}; // ADD overflow
    sc_tab[1]  = '{4'h0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0}; // ADDU no flag
    sc_tab[2]  = '{4'h1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0}; // SUBU wrap
    sc_tab[3]  = '{4'h2, 32'hF0F00000, 32'h0000F0F0, 32'hF0F0F0F0, 1'b0}; // OR
    sc_tab[4]  = '{4'h3, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0}; // SLT signed
    sc_tab[5]  = '{4'h4, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0}; // ADD to zero
    sc_tab[6]  = '{4'h5, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1}; // SUB overflow
    sc_tab[7]  = '{4'h5, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0}; // SUB negative
    sc_tab[8]  = '{4'h6, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0}; // AND
    sc_tab[9]  = '{4'h7, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0}; // XOR
    sc_tab[10] = '{4'h8, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0}; // NOR
    sc_tab[11] = '{4'h9, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0}; // SLTU false
    sc_tab[12] = '{4'h9, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0}; // SLTU true
    sc_tab[13] = '{4'hE, 32'h12345678, 32'h00000001, 32'h00000000, 1'b0}; // illegal
    sc_tab[14] = '{4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0}; // illegal

    md_tab[0]  = '{4'hA, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0}; // -3*5
    md_tab[1]  = '{4'hB, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    md_tab[2]  = '{4'hA, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0}; // -1*-1
    md_tab[3]  = '{4'hA, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0}; // 2^62
    md_tab[4]  = '{4'hA, 32'h00000007, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0};
    md_tab[5]  = '{4'hC, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0}; // -7/2
    md_tab[6]  = '{4'hC, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0}; // 7/-2
    md_tab[7]  = '{4'hD, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0}; // 100/7
    md_tab[8]  = '{4'hD, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1}; // /0
    md_tab[9]  = '{4'hC, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1}; // /0
    md_tab[10] = '{4'hC, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b1}; // MIN/-1

    bus.start = 1'b0;
    bus.op    = 4'h0;
    bus.a     = '0;
    bus.b     = '0;
    reset     = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy",   32'(bus.busy),     32'd0);
    check("rst_done",   32'(bus.done),     32'd0);
    check("rst_result", bus.result,        32'd0);
    check("rst_zero",   32'(bus.zero),     32'd0);
    check("rst_ovf",    32'(bus.overflow), 32'd0);
    check("rst_hi",     bus.hi,            32'd0);
    check("rst_lo",     bus.lo,            32'd0);
    reset = 1'b0;

    // Single-cycle ops
    for (int i = 0; i < 15; i++) begin
      run_op(sc_tab[i].op, sc_tab[i].a, sc_tab[i].b, 0, lat);
      check($sformatf("sc%0d_lat", i),  32'(lat),          32'd1);
      check($sformatf("sc%0d_busy", i), 32'(bus.busy),     32'd0);
      check($sformatf("sc%0d_res", i),  bus.result,        sc_tab[i].res);
      check($sformatf("sc%0d_zero", i), 32'(bus.zero),     32'(sc_tab[i].res == 32'd0));
      check($sformatf("sc%0d_ovf", i),  32'(bus.overflow), 32'(sc_tab[i].ovf));
    end
    check("sc_hi_hold", bus.hi, 32'd0);
    check("sc_lo_hold", bus.lo, 32'd0);

    // Multiply / divide
    for (int i = 0; i < 11; i++) begin
      run_op(md_tab[i].op, md_tab[i].a, md_tab[i].b, 0, lat);
      check($sformatf("md%0d_lat", i),  32'(lat),          32'd34);
      check($sformatf("md%0d_hi", i),   bus.hi,            md_tab[i].hi);
      check($sformatf("md%0d_lo", i),   bus.lo,            md_tab[i].lo);
      check($sformatf("md%0d_res", i),  bus.result,        md_tab[i].lo);
      check($sformatf("md%0d_zero", i), 32'(bus.zero),     32'(md_tab[i].lo == 32'd0));
      check($sformatf("md%0d_ovf", i),  32'(bus.overflow), 32'(md_tab[i].ovf));
    end

    // Illegal op leaves HI/LO from the last divide untouched
    run_op(4'hE, 32'h1, 32'h2, 0, lat);
    check("ill_res",  bus.result,        32'd0);
    check("ill_zero", 32'(bus.zero),     32'd1);
    check("ill_ovf",  32'(bus.overflow), 32'd0);
    check("ill_hi",   bus.hi,            32'h00000000);
    check("ill_lo",   bus.lo,            32'h80000000);

    // Back-to-back: SUBU then SLT accepted in the DONE cycle
    run_op(4'h1, 32'd5, 32'd5, 0, lat);
    check("b2b_subu_res",  bus.result,    32'd0);
    check("b2b_subu_zero", 32'(bus.zero), 32'd1);
    bus.start = 1'b1;
    bus.op    = 4'h3;
    bus.a     = 32'hFFFFFFFF;
    bus.b     = 32'd1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_slt_done", 32'(bus.done),  32'd1);
    check("b2b_slt_res",  bus.result,     32'd1);
    check("b2b_slt_zero", 32'(bus.zero),  32'd0);

    // Start while busy is ignored
    run_op(4'hB, 32'd3, 32'd4, 5, lat);
    check("poke_lat", 32'(lat),   32'd34);
    check("poke_hi",  bus.hi,     32'd0);
    check("poke_lo",  bus.lo,     32'd12);
    check("poke_res", bus.result, 32'd12);
    check("poke_ovf", 32'(bus.overflow), 32'd0);

    // Asynchronous reset in the middle of a multiply
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 4'hB;
    bus.a     = 32'd9;
    bus.b     = 32'd9;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("mid_busy", 32'(bus.busy), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("arst_busy",   32'(bus.busy),     32'd0);
    check("arst_done",   32'(bus.done),     32'd0);
    check("arst_hi",     bus.hi,            32'd0);
    check("arst_lo",     bus.lo,            32'd0);
    check("arst_result", bus.result,        32'd0);
    check("arst_zero",   32'(bus.zero),     32'd0);
    @(negedge clk);
    reset  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    check("arst_no_done", 32'(pulses), 32'd0);
    check("arst_idle_busy", 32'(bus.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
